// File: rtl/j10_pkg.sv
// Shared definitions for the 10-instruction processor boot path:
// loader states, opcode encodings and instruction field positions.
package j10_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FLUSH   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } loader_state_t;

    localparam logic [3:0] LD  = 4'b0001;
    localparam logic [3:0] ST  = 4'b0010;
    localparam logic [3:0] BRA = 4'b0011;
    localparam logic [3:0] ADD = 4'b0101;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int MODE_MSB   = 27;
    localparam int MODE_LSB   = 24;
    localparam int SRC_MSB    = 23;
    localparam int SRC_LSB    = 12;
    localparam int DST_MSB    = 11;
    localparam int DST_LSB    = 0;

    // Assemble one instruction word from its fields.
    function automatic logic [31:0] make_instr(
        input logic [3:0]  opcode,
        input logic [3:0]  mode,
        input logic [11:0] src,
        input logic [11:0] dst
    );
        logic [31:0] word;
        word = '0;
        word[OPCODE_MSB:OPCODE_LSB] = opcode;
        word[MODE_MSB:MODE_LSB]     = mode;
        word[SRC_MSB:SRC_LSB]       = src;
        word[DST_MSB:DST_LSB]       = dst;
        return word;
    endfunction

endpackage

// File: rtl/instr_load_ctrl.sv
// Boot sequencer: streams instruction words into consecutive processor RAM
// addresses through the init-write port, holding the processor in reset meanwhile.
module instr_load_ctrl
    import j10_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int RESET_HOLD    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic [ADDRESS_WIDTH-1:0] load_base,
    input  logic [ADDRESS_WIDTH:0]   load_count,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_init_wadrs,
    output logic [DATA_WIDTH-1:0]    ram_write_instruction,
    output logic                     initialize_instructions,
    output logic                     proc_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDRESS_WIDTH+1:0] DEPTH = (ADDRESS_WIDTH+2)'(1) << ADDRESS_WIDTH;

    loader_state_t              state, state_nxt;
    logic [ADDRESS_WIDTH-1:0]   addr, addr_nxt;
    logic [ADDRESS_WIDTH:0]     remaining, remaining_nxt;
    logic [HOLD_W-1:0]          hold_cnt, hold_cnt_nxt;
    logic [ADDRESS_WIDTH-1:0]   wadrs_nxt;
    logic [DATA_WIDTH-1:0]      wdata_nxt;
    logic                       init_nxt;
    logic                       proc_reset_nxt;
    logic                       busy_nxt;
    logic                       done_nxt;
    logic                       error_nxt;
    logic                       accept;
    logic [ADDRESS_WIDTH+1:0]   load_end;
    logic                       range_ok;

    assign in_ready = (state == LOAD) && (remaining != '0);
    assign accept   = in_valid && in_ready;

    // One past the last address written; a load may end exactly at the top of RAM.
    assign load_end = {2'b00, load_base} + {1'b0, load_count};
    assign range_ok = (load_end <= DEPTH);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        hold_cnt_nxt  = '0;
        wadrs_nxt     = ram_init_wadrs;
        wdata_nxt     = ram_write_instruction;
        init_nxt      = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = error;

        case (state)
            IDLE, RUN: begin
                if (load_start) begin
                    if (!range_ok) begin
                        error_nxt = 1'b1;
                    end else begin
                        error_nxt     = 1'b0;
                        addr_nxt      = load_base;
                        remaining_nxt = load_count;
                        state_nxt     = (load_count == '0) ? RELEASE : LOAD;
                    end
                end
            end

            LOAD: begin
                if (accept) begin
                    init_nxt      = 1'b1;
                    wadrs_nxt     = addr;
                    wdata_nxt     = in_data;
                    addr_nxt      = addr + ADDRESS_WIDTH'(1);
                    remaining_nxt = remaining - (ADDRESS_WIDTH+1)'(1);
                    if (remaining == (ADDRESS_WIDTH+1)'(1)) begin
                        state_nxt = FLUSH;
                    end
                end
            end

            FLUSH: begin
                state_nxt = RELEASE;
            end

            RELEASE: begin
                if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Processor is held in reset in every state except RUN, including a reload from RUN.
        proc_reset_nxt = (state_nxt != RUN);
        busy_nxt       = (state_nxt == LOAD) || (state_nxt == FLUSH) || (state_nxt == RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state                   <= IDLE;
            addr                    <= '0;
            remaining               <= '0;
            hold_cnt                <= '0;
            ram_init_wadrs          <= '0;
            ram_write_instruction   <= '0;
            initialize_instructions <= 1'b0;
            proc_reset              <= 1'b1;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            error                   <= 1'b0;
        end else begin
            state                   <= state_nxt;
            addr                    <= addr_nxt;
            remaining               <= remaining_nxt;
            hold_cnt                <= hold_cnt_nxt;
            ram_init_wadrs          <= wadrs_nxt;
            ram_write_instruction   <= wdata_nxt;
            initialize_instructions <= init_nxt;
            proc_reset              <= proc_reset_nxt;
            busy                    <= busy_nxt;
            done                    <= done_nxt;
            error                   <= error_nxt;
        end
    end

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Directed bench for instr_load_ctrl: expected RAM writes are queued as beats
// are accepted and compared when the init-write port fires.
module tb_instr_load_ctrl;
    import j10_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 12;
    localparam int HOLD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_count = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [AW-1:0] ram_init_wadrs;
    logic [DW-1:0] ram_write_instruction;
    logic          initialize_instructions;
    logic          proc_reset;
    logic          busy;
    logic          done;
    logic          error;

    instr_load_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .RESET_HOLD   (HOLD)
    ) dut (
        .clk                    (clk),
        .reset                  (rst_n),
        .load_start             (load_start),
        .load_base              (load_base),
        .load_count             (load_count),
        .in_valid               (in_valid),
        .in_data                (in_data),
        .in_ready               (in_ready),
        .ram_init_wadrs         (ram_init_wadrs),
        .ram_write_instruction  (ram_write_instruction),
        .initialize_instructions(initialize_instructions),
        .proc_reset             (proc_reset),
        .busy                   (busy),
        .done                   (done),
        .error                  (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] adrs;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           exp_wr;
    logic [AW-1:0] model_addr = '0;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every init write must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n && initialize_instructions) begin
            check_val("write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                exp_wr = exp_q.pop_front();
                check_val("write_adrs", 64'(ram_init_wadrs), 64'(exp_wr.adrs));
                check_val("write_data", 64'(ram_write_instruction), 64'(exp_wr.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check_val({tag, "_wadrs"}, 64'(ram_init_wadrs), 64'(0));
        check_val({tag, "_wdata"}, 64'(ram_write_instruction), 64'(0));
        check_val({tag, "_init"}, 64'(initialize_instructions), 64'(0));
        check_val({tag, "_proc_reset"}, 64'(proc_reset), 64'(1));
        check_val({tag, "_busy"}, 64'(busy), 64'(0));
        check_val({tag, "_done"}, 64'(done), 64'(0));
        check_val({tag, "_error"}, 64'(error), 64'(0));
        check_val({tag, "_state"}, 64'(dut.state), 64'(IDLE));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values(tag);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] count);
        load_base  = base;
        load_count = count;
        load_start = 1'b1;
        model_addr = base;
        tick();
        load_start = 1'b0;
    endtask

    // Present one word and hold it until accepted; the write lands one cycle later.
    task automatic send_word(input logic [DW-1:0] w);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_val("ready_timeout", 64'(waited >= 20), 64'(0));
        if (in_ready) begin
            exp_q.push_back('{adrs: model_addr, data: w});
            model_addr = model_addr + AW'(1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        tick();
    endtask

    // Counts cycles until done, and how many of those had proc_reset still high.
    task automatic wait_done(output int cycles, output int prst_high);
        cycles    = 0;
        prst_high = 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
            if (!done && proc_reset) prst_high++;
        end
        check_val("done_seen", 64'(done), 64'(1));
    endtask

    int cyc;
    int hi;

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_values("idle");

        // Basic load: two back-to-back words at 0x000.
        start_load(12'h000, 13'd2);
        check_val("basic_state", 64'(dut.state), 64'(LOAD));
        check_val("basic_ready", 64'(in_ready), 64'(1));
        check_val("basic_busy", 64'(busy), 64'(1));
        send_word(make_instr(ADD, 4'hC, 12'h000, 12'h001));
        send_word(make_instr(BRA, 4'h0, 12'h000, 12'h009));
        check_val("basic_flush_state", 64'(dut.state), 64'(FLUSH));
        check_val("basic_flush_ready", 64'(in_ready), 64'(0));
        check_val("basic_flush_init", 64'(initialize_instructions), 64'(1));
        wait_done(cyc, hi);
        // FLUSH cycle is followed by HOLD RELEASE cycles before RUN.
        check_val("basic_done_latency", 64'(cyc), 64'(HOLD + 1));
        check_val("basic_prst_hold", 64'(hi), 64'(HOLD));
        check_val("basic_run_prst", 64'(proc_reset), 64'(0));
        check_val("basic_run_busy", 64'(busy), 64'(0));
        tick();
        check_val("basic_done_pulse", 64'(done), 64'(0));
        check_val("basic_run_state", 64'(dut.state), 64'(RUN));

        // Reload from RUN with in_valid gaps 1,0,1,1,0,1.
        start_load(12'h009, 13'd4);
        check_val("gap_prst_reassert", 64'(proc_reset), 64'(1));
        check_val("gap_state", 64'(dut.state), 64'(LOAD));
        send_word(make_instr(LD, 4'h1, 12'h100, 12'h200));
        idle_cycle();
        send_word(make_instr(ST, 4'h2, 12'h101, 12'h201));
        send_word(make_instr(ADD, 4'h3, 12'h102, 12'h202));
        idle_cycle();
        send_word(make_instr(BRA, 4'h4, 12'h103, 12'h203));
        check_val("gap_ready_after_last", 64'(in_ready), 64'(0));
        wait_done(cyc, hi);
        check_val("gap_done_latency", 64'(cyc), 64'(HOLD + 1));

        // Range error while running leaves the processor alone.
        start_load(12'hFFF, 13'd2);
        check_val("run_err_error", 64'(error), 64'(1));
        check_val("run_err_state", 64'(dut.state), 64'(RUN));
        check_val("run_err_prst", 64'(proc_reset), 64'(0));

        // Range error from IDLE, then a load ending exactly at the top address.
        do_reset("rst_a");
        start_load(12'hFFE, 13'd3);
        check_val("idle_err_error", 64'(error), 64'(1));
        check_val("idle_err_state", 64'(dut.state), 64'(IDLE));
        check_val("idle_err_prst", 64'(proc_reset), 64'(1));
        check_val("idle_err_ready", 64'(in_ready), 64'(0));
        repeat (3) idle_cycle();
        start_load(12'hFFE, 13'd2);
        check_val("top_error_clear", 64'(error), 64'(0));
        check_val("top_state", 64'(dut.state), 64'(LOAD));
        send_word(32'hDEAD_0FFE);
        send_word(32'hBEEF_0FFF);
        wait_done(cyc, hi);
        check_val("top_done_latency", 64'(cyc), 64'(HOLD + 1));

        // Zero count: straight to RELEASE, proc_reset still pulsed for HOLD cycles.
        do_reset("rst_b");
        start_load(12'h000, 13'd0);
        check_val("zero_state", 64'(dut.state), 64'(RELEASE));
        check_val("zero_prst", 64'(proc_reset), 64'(1));
        check_val("zero_busy", 64'(busy), 64'(1));
        wait_done(cyc, hi);
        // The first RELEASE cycle is already current when counting starts.
        check_val("zero_done_latency", 64'(cyc), 64'(HOLD));
        check_val("zero_prst_hold", 64'(hi), 64'(HOLD - 1));
        check_val("zero_run_prst", 64'(proc_reset), 64'(0));
        tick();
        start_load(12'h010, 13'd1);
        check_val("reload_prst", 64'(proc_reset), 64'(1));
        check_val("reload_state", 64'(dut.state), 64'(LOAD));
        send_word(make_instr(LD, 4'h0, 12'h010, 12'h011));
        wait_done(cyc, hi);
        check_val("reload_done_latency", 64'(cyc), 64'(HOLD + 1));

        // Out-of-range load_start during LOAD is ignored entirely.
        start_load(12'h020, 13'd3);
        send_word(32'h1111_0020);
        load_base  = 12'hFFF;
        load_count = 13'd5;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check_val("ign_state", 64'(dut.state), 64'(LOAD));
        check_val("ign_error", 64'(error), 64'(0));
        check_val("ign_ready", 64'(in_ready), 64'(1));
        send_word(32'h2222_0021);
        send_word(32'h3333_0022);
        wait_done(cyc, hi);
        check_val("ign_error_end", 64'(error), 64'(0));

        // Asynchronous reset after two of five beats.
        start_load(12'h030, 13'd5);
        send_word(32'hA000_0030);
        send_word(32'hA000_0031);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        repeat (2) @(posedge clk);
        #1;
        check_val("async_held_prst", 64'(proc_reset), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("async_idle_state", 64'(dut.state), 64'(IDLE));

        check_val("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
